// File: rtl/serial_pkg.sv
// Shared types and constants for the single-bit registered serial link.
// Used by the transmitter now and by the receiver later.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Clocks occupied by one frame, excluding the mandatory idle cycle between frames.
    function automatic int unsigned frame_cycles(input int unsigned data_width,
                                                 input int unsigned stop_bits,
                                                 input int unsigned clk_per_bit);
        return (1 + data_width + stop_bits) * clk_per_bit;
    endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// Bit-period counter: emits a one-cycle tick on the last clock of each bit period.
// A synchronous clear restarts the period so the first bit after a load is full length.
module serial_baud_tick #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic aclk,
    input  logic arstn,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With CLK_PER_BIT=1 LAST is zero, so the tick fires every enabled cycle.
    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_WIDTH data bits LSB-first, STOP_BITS stop bits.
// All outputs are registered; tx_valid/tx_data are only looked at while tx_ready is high.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_PER_BIT = 4,
    parameter int STOP_BITS   = 1
) (
    input  logic                  aclk,
    input  logic                  arstn,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  txd,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Handshake: a word transfers on a rising aclk edge where tx_valid and tx_ready are both 1.
    // tx_ready is high only in IDLE, so the upstream may change tx_valid/tx_data freely while busy.

    localparam int BW = $clog2(DATA_WIDTH + 1);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [BW-1:0]         bit_q;
    logic                  txd_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  handshake;
    logic                  tick;

    assign handshake = tx_valid && ready_q;
    assign shift_nxt = shift_q >> 1;

    serial_baud_tick #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_baud (
        .aclk    (aclk),
        .arstn   (arstn),
        .clear_i (handshake),
        .en_i    (busy_q),
        .tick_o  (tick)
    );

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= LINE_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        state_q <= START;
                        shift_q <= tx_data;
                        bit_q   <= '0;
                        txd_q   <= START_LEVEL;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        txd_q   <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= shift_nxt;
                        if (bit_q == BW'(DATA_WIDTH - 1)) begin
                            state_q <= STOP;
                            bit_q   <= '0;
                            txd_q   <= LINE_IDLE;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            txd_q <= shift_nxt[0];
                        end
                    end
                end
                STOP: begin
                    // bit_q is reused to count stop bits; ready rises as the line goes idle.
                    if (tick) begin
                        if (bit_q == BW'(STOP_BITS - 1)) begin
                            state_q <= IDLE;
                            bit_q   <= '0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign txd       = txd_q;
    assign tx_ready  = ready_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed + randomized bench for serial_tx: two instances (CLK_PER_BIT=4/STOP_BITS=1 and
// CLK_PER_BIT=1/STOP_BITS=2) compared cycle by cycle against a frame-level line model.
module tb_serial_tx;
    import serial_pkg::*;

    logic       aclk;
    logic       arstn;

    logic       a_valid;
    logic       a_ready;
    logic [7:0] a_data;
    logic       a_txd;
    logic       a_busy;
    logic [1:0] a_state;

    logic       c_valid;
    logic       c_ready;
    logic [7:0] c_data;
    logic       c_txd;
    logic       c_busy;
    logic [1:0] c_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_q[$];
    logic [0:0] exp_q[$];

    serial_tx #(.DATA_WIDTH(8), .CLK_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .aclk (aclk), .arstn (arstn), .tx_valid (a_valid), .tx_ready (a_ready),
        .tx_data (a_data), .txd (a_txd), .busy (a_busy), .dbg_state (a_state)
    );

    serial_tx #(.DATA_WIDTH(8), .CLK_PER_BIT(1), .STOP_BITS(2)) dut_c (
        .aclk (aclk), .arstn (arstn), .tx_valid (c_valid), .tx_ready (c_ready),
        .tx_data (c_data), .txd (c_txd), .busy (c_busy), .dbg_state (c_state)
    );

    // Clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Handshake log for instance A (cycle index of each accepting edge)
    always @(posedge aclk) begin
        cyc++;
        if (a_valid && a_ready) hs_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line model: each frame bit is held for cpb clocks.
    function automatic void push_frame(input logic [7:0] w, input int cpb, input int sb);
        logic [0:0] b;
        for (int i = 0; i < 9 + sb; i++) begin
            if (i == 0)      b = 1'b0;
            else if (i <= 8) b = w[i-1];
            else             b = 1'b1;
            for (int j = 0; j < cpb; j++) exp_q.push_back(b);
        end
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            c_valid = v;
            c_data  = d;
        end else begin
            a_valid = v;
            a_data  = d;
        end
    endtask

    task automatic wait_ready(input bit sel, input string tag);
        int guard = 0;
        @(negedge aclk);
        while (!(sel ? c_ready : a_ready) && guard < 200) begin
            @(negedge aclk);
            guard++;
        end
        check(tag, sel ? c_ready : a_ready, 1);
    endtask

    // One frame with garbage on the inputs while busy; loopback capture at mid-bit.
    task automatic send_frame(input bit sel, input logic [7:0] w, input string tag);
        int cpb = sel ? 1 : 4;
        int sb  = sel ? 2 : 1;
        int n   = (9 + sb) * cpb;
        logic [7:0] cap = '0;
        logic [0:0] e;
        wait_ready(sel, {tag, "_rdy"});
        drive(sel, 1'b1, w);
        @(posedge aclk);
        @(negedge aclk);
        exp_q.delete();
        push_frame(w, cpb, sb);
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            check({tag, "_txd"}, sel ? c_txd : a_txd, e);
            check({tag, "_busy"}, sel ? c_busy : a_busy, 1);
            if ((k % cpb) == cpb / 2 && k / cpb >= 1 && k / cpb <= 8)
                cap[k / cpb - 1] = sel ? c_txd : a_txd;
            drive(sel, (k < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom));
            @(negedge aclk);
        end
        check({tag, "_end_busy"}, sel ? c_busy : a_busy, 0);
        check({tag, "_end_txd"}, sel ? c_txd : a_txd, 1);
        check({tag, "_end_rdy"}, sel ? c_ready : a_ready, 1);
        check({tag, "_loopback"}, cap, w);
    endtask

    // Two frames on instance A; w2 is offered from change_k onwards (0 = tx_valid held throughout).
    task automatic send_pair(input logic [7:0] w1, input logic [7:0] w2, input int change_k,
                             input string tag);
        int hs0;
        logic [0:0] e;
        wait_ready(1'b0, {tag, "_rdy"});
        hs0 = hs_q.size();
        drive(1'b0, 1'b1, w1);
        @(posedge aclk);
        @(negedge aclk);
        exp_q.delete();
        push_frame(w1, 4, 1);
        exp_q.push_back(1'b1);
        push_frame(w2, 4, 1);
        for (int k = 0; k < 81; k++) begin
            e = exp_q.pop_front();
            check({tag, "_txd"}, a_txd, e);
            if (k == 40) check({tag, "_gap_rdy"}, a_ready, 1);
            if (k == 20) check({tag, "_mid_rdy"}, a_ready, 0);
            if (k == 0) drive(1'b0, change_k == 0, (change_k == 0) ? w2 : 8'($urandom));
            if (change_k > 0 && k == change_k) drive(1'b0, 1'b1, w2);
            if (k == 41) drive(1'b0, 1'b0, 8'($urandom));
            @(negedge aclk);
        end
        check({tag, "_end_busy"}, a_busy, 0);
        check({tag, "_hs_count"}, hs_q.size() - hs0, 2);
        if (hs_q.size() - hs0 == 2) check({tag, "_hs_gap"}, hs_q[hs0+1] - hs_q[hs0], 41);
    endtask

    initial begin
        int hs0;
        logic [7:0] w;
        arstn   = 1'b0;
        a_valid = 1'b0;
        a_data  = '0;
        c_valid = 1'b0;
        c_data  = '0;

        // Reset state
        #100;
        check("rst_txd", a_txd, 1);
        check("rst_rdy", a_ready, 0);
        check("rst_busy", a_busy, 0);
        check("rst_state", a_state, IDLE);
        check("rst_c_txd", c_txd, 1);
        check("rst_c_rdy", c_ready, 0);

        // Release with tx_valid already high: not accepted on the first edge
        @(negedge aclk);
        arstn = 1'b1;
        drive(1'b0, 1'b1, 8'h55);
        drive(1'b1, 1'b1, 8'h55);
        @(posedge aclk);
        #1;
        check("rel_rdy", a_ready, 1);
        check("rel_busy", a_busy, 0);
        check("rel_c_rdy", c_ready, 1);
        check("rel_c_busy", c_busy, 0);
        check("rel_no_hs", hs_q.size(), 0);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);

        // Single frames
        send_frame(1'b0, 8'hA5, "a5");
        send_pair(8'h00, 8'hFF, 0, "b2b");
        send_pair($urandom, 8'h3C, 20, "chg");

        // Reset in the middle of data bit 3
        w = 8'($urandom);
        wait_ready(1'b0, "mrst_rdy");
        drive(1'b0, 1'b1, w);
        @(posedge aclk);
        @(negedge aclk);
        drive(1'b0, 1'b0, 8'h00);
        repeat (17) @(negedge aclk);
        check("mrst_bit3", a_txd, w[3]);
        #2 arstn = 1'b0;
        #1;
        check("mrst_txd", a_txd, 1);
        check("mrst_busy", a_busy, 0);
        check("mrst_rdy", a_ready, 0);
        @(negedge aclk);
        arstn = 1'b1;
        hs0 = hs_q.size();
        for (int k = 0; k < 50; k++) begin
            check("post_txd", a_txd, 1);
            check("post_busy", a_busy, 0);
            @(negedge aclk);
        end
        check("post_rdy", a_ready, 1);
        check("post_no_hs", hs_q.size(), hs0);

        // Randomized frames on both instances
        for (int i = 0; i < 4; i++) send_frame(1'b0, 8'($urandom), "rnd_a");
        send_frame(1'b1, 8'h81, "c81");
        for (int i = 0; i < 4; i++) send_frame(1'b1, 8'($urandom), "rnd_c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
